// File: rtl/debounce_sync.sv
// Input conditioner: two-flop synchronizer followed by a stable-count
// qualifier that drives a clean level plus rise/fall strobes and debug state.
module debounce_sync #(
    parameter int unsigned STABLE_CYCLES = 4,   // legal range 2..255
    parameter int unsigned CNT_W         = 8    // 2**CNT_W must exceed STABLE_CYCLES
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       din,
    output logic       d_out,
    output logic       rise,
    output logic       fall,
    output logic       busy,
    output logic [7:0] glitch_cnt
);

    typedef enum logic [1:0] {
        IDLE_LOW  = 2'b00,
        CHK_HIGH  = 2'b01,
        IDLE_HIGH = 2'b10,
        CHK_LOW   = 2'b11
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [7:0]       GLITCH_MAX = 8'hFF;

    logic             sync1;
    logic             sync2;
    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             d_nxt;
    logic             rise_nxt;
    logic             fall_nxt;
    logic             glitch_hit;

    // Only sync2 is allowed to reach the qualifier; sync1 may be metastable.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of its neighbours, which is what makes
    // sync1 -> sync2 a real two-stage pipeline.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
        end else begin
            sync1 <= din;
            sync2 <= sync1;
        end
    end

    // NOTE: every signal written here gets a default first, so no path
    // through the case can leave one unassigned and infer a latch.
    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        d_nxt      = d_out;
        rise_nxt   = 1'b0;
        fall_nxt   = 1'b0;
        glitch_hit = 1'b0;

        unique case (state)
            IDLE_LOW: begin
                if (sync2) begin
                    state_nxt = CHK_HIGH;
                    cnt_nxt   = CNT_W'(1);
                end
            end

            CHK_HIGH: begin
                if (!sync2) begin
                    state_nxt  = IDLE_LOW;
                    cnt_nxt    = '0;
                    glitch_hit = 1'b1;
                end else if (cnt == CNT_LAST) begin
                    state_nxt = IDLE_HIGH;
                    cnt_nxt   = '0;
                    d_nxt     = 1'b1;
                    rise_nxt  = 1'b1;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end

            IDLE_HIGH: begin
                if (!sync2) begin
                    state_nxt = CHK_LOW;
                    cnt_nxt   = CNT_W'(1);
                end
            end

            CHK_LOW: begin
                if (sync2) begin
                    state_nxt  = IDLE_HIGH;
                    cnt_nxt    = '0;
                    glitch_hit = 1'b1;
                end else if (cnt == CNT_LAST) begin
                    state_nxt = IDLE_LOW;
                    cnt_nxt   = '0;
                    d_nxt     = 1'b0;
                    fall_nxt  = 1'b1;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end

            default: begin
                state_nxt = IDLE_LOW;
                cnt_nxt   = '0;
            end
        endcase
    end

    // Reset abandons any qualification in progress without a strobe or a
    // glitch count, so a level held across release is requalified from scratch.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE_LOW;
            cnt        <= '0;
            d_out      <= 1'b0;
            rise       <= 1'b0;
            fall       <= 1'b0;
            glitch_cnt <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            d_out <= d_nxt;
            rise  <= rise_nxt;
            fall  <= fall_nxt;
            if (glitch_hit && (glitch_cnt != GLITCH_MAX)) begin
                glitch_cnt <= glitch_cnt + 8'd1;
            end
        end
    end

    assign busy = (state == CHK_HIGH) || (state == CHK_LOW);

endmodule

// File: tb/tb_debounce_sync.sv
// Directed self-checking bench for debounce_sync with STABLE_CYCLES=4.
// Inputs are driven and outputs sampled 1 time unit after each rising edge.
module tb_debounce_sync;

    logic       clk;
    logic       rst;
    logic       din;
    logic       d_out;
    logic       rise;
    logic       fall;
    logic       busy;
    logic [7:0] glitch_cnt;

    int n_checks = 0;
    int n_errors = 0;

    // Pulse/level tallies sampled mid-cycle; steps compare deltas of these.
    int rise_seen = 0;
    int fall_seen = 0;
    int both_seen = 0;
    int high_seen = 0;

    debounce_sync #(
        .STABLE_CYCLES(4),
        .CNT_W        (8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .din       (din),
        .d_out     (d_out),
        .rise      (rise),
        .fall      (fall),
        .busy      (busy),
        .glitch_cnt(glitch_cnt)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    always @(negedge clk) begin
        if (rise) rise_seen++;
        if (fall) fall_seen++;
        if (rise && fall) both_seen++;
        if (d_out) high_seen++;
    end

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin : stim
        int r0;
        int f0;
        int h0;

        rst = 1'b1;
        din = 1'b0;

        // Reset held for two edges while din toggles.
        tick(); din = 1'b1;
        tick(); din = 1'b0;
        check("rst_d_out", {7'd0, d_out}, 8'd0);
        check("rst_rise", {7'd0, rise}, 8'd0);
        check("rst_fall", {7'd0, fall}, 8'd0);
        check("rst_busy", {7'd0, busy}, 8'd0);
        check("rst_glitch", glitch_cnt, 8'd0);
        rst = 1'b0;
        tick(3);
        check("idle_busy", {7'd0, busy}, 8'd0);
        check("idle_d_out", {7'd0, d_out}, 8'd0);

        // Clean rise: din goes high just before E0.
        r0 = rise_seen;
        f0 = fall_seen;
        din = 1'b1;
        tick();                                  // E0
        tick();                                  // E1
        check("rise_busy_e1", {7'd0, busy}, 8'd0);
        tick();                                  // E2
        check("rise_busy_e2", {7'd0, busy}, 8'd1);
        tick(2);                                 // E4
        check("rise_d_e4", {7'd0, d_out}, 8'd0);
        check("rise_busy_e4", {7'd0, busy}, 8'd1);
        tick();                                  // E5
        check("rise_d_e5", {7'd0, d_out}, 8'd1);
        check("rise_pulse_e5", {7'd0, rise}, 8'd1);
        check("rise_busy_e5", {7'd0, busy}, 8'd0);
        tick();                                  // E6
        check("rise_pulse_e6", {7'd0, rise}, 8'd0);
        check("rise_d_e6", {7'd0, d_out}, 8'd1);
        check("rise_count", 8'(rise_seen - r0), 8'd1);
        check("rise_no_fall", 8'(fall_seen - f0), 8'd0);

        // Clean fall from d_out=1.
        r0 = rise_seen;
        f0 = fall_seen;
        din = 1'b0;
        tick(3);                                 // E2
        check("fall_busy_e2", {7'd0, busy}, 8'd1);
        tick(2);                                 // E4
        check("fall_d_e4", {7'd0, d_out}, 8'd1);
        check("fall_pulse_e4", {7'd0, fall}, 8'd0);
        tick();                                  // E5
        check("fall_d_e5", {7'd0, d_out}, 8'd0);
        check("fall_pulse_e5", {7'd0, fall}, 8'd1);
        check("fall_busy_e5", {7'd0, busy}, 8'd0);
        tick();                                  // E6
        check("fall_pulse_e6", {7'd0, fall}, 8'd0);
        check("fall_count", 8'(fall_seen - f0), 8'd1);
        check("fall_no_rise", 8'(rise_seen - r0), 8'd0);
        check("fall_glitch", glitch_cnt, 8'd0);

        // Reset at E3 of a rise, released with din still high.
        r0 = rise_seen;
        din = 1'b1;
        tick(3);                                 // E2
        check("rmid_busy_e2", {7'd0, busy}, 8'd1);
        rst = 1'b1;
        tick();                                  // E3, reset sampled
        check("rmid_busy_rst", {7'd0, busy}, 8'd0);
        check("rmid_d_rst", {7'd0, d_out}, 8'd0);
        check("rmid_glitch_rst", glitch_cnt, 8'd0);
        rst = 1'b0;
        tick();                                  // E'0
        tick();                                  // E'1
        check("rmid_busy_e1", {7'd0, busy}, 8'd0);
        tick(3);                                 // E'4
        check("rmid_d_e4", {7'd0, d_out}, 8'd0);
        check("rmid_no_rise_yet", 8'(rise_seen - r0), 8'd0);
        tick();                                  // E'5
        check("rmid_d_e5", {7'd0, d_out}, 8'd1);
        check("rmid_rise_e5", {7'd0, rise}, 8'd1);
        tick();
        check("rmid_rise_count", 8'(rise_seen - r0), 8'd1);
        check("rmid_glitch", glitch_cnt, 8'd0);

        // Return low before the bounce test.
        din = 1'b0;
        tick(6);
        check("ret_low_d", {7'd0, d_out}, 8'd0);

        // Bounce: high 2 cycles, low 1, then high held.
        r0 = rise_seen;
        din = 1'b1;
        tick();                                  // E0
        tick();                                  // E1
        din = 1'b0;
        tick();                                  // E2: sync1=0, FSM enters CHK_HIGH
        din = 1'b1;
        tick();                                  // E3: final capture of 1
        check("bnc_busy_e3", {7'd0, busy}, 8'd1);
        tick();                                  // E4: abort seen
        check("bnc_glitch", glitch_cnt, 8'd1);
        check("bnc_busy_abort", {7'd0, busy}, 8'd0);
        check("bnc_d_abort", {7'd0, d_out}, 8'd0);
        tick(3);                                 // E7 = capture+4
        check("bnc_d_e7", {7'd0, d_out}, 8'd0);
        check("bnc_busy_e7", {7'd0, busy}, 8'd1);
        tick();                                  // E8 = capture+5
        check("bnc_d_e8", {7'd0, d_out}, 8'd1);
        check("bnc_rise_e8", {7'd0, rise}, 8'd1);
        tick(2);
        check("bnc_rise_count", 8'(rise_seen - r0), 8'd1);
        check("bnc_glitch_hold", glitch_cnt, 8'd1);

        din = 1'b0;
        tick(6);
        check("ret_low2_d", {7'd0, d_out}, 8'd0);

        // Saturation: 300 single-sample bounces, glitch_cnt starts at 1.
        h0 = high_seen;
        for (int b = 0; b < 300; b++) begin
            din = 1'b1;
            tick();
            din = 1'b0;
            tick(3);
            if (b == 99) check("sat_glitch_100", glitch_cnt, 8'd101);
            if (b == 253) check("sat_glitch_254", glitch_cnt, 8'd255);
        end
        tick(3);
        check("sat_glitch_end", glitch_cnt, 8'd255);
        check("sat_d_out", {7'd0, d_out}, 8'd0);
        check("sat_d_never_high", 8'(high_seen - h0), 8'd0);
        check("sat_busy", {7'd0, busy}, 8'd0);

        check("never_rise_and_fall", 8'(both_seen), 8'd0);

        // Reset is the only way to clear the glitch counter.
        rst = 1'b1;
        tick();
        check("final_rst_glitch", glitch_cnt, 8'd0);
        rst = 1'b0;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/debounce_sync.md
# debounce_sync

Input conditioner that sits directly upstream of the latch-based master-slave D flip-flop. It brings a raw, asynchronous, possibly bouncing input into the `clk` domain through a two-flop synchronizer. The input is then qualified by a stable-count state machine, and the clean level is driven onto the flip-flop's `d` input. It also provides one-cycle rise and fall strobes, a busy flag and a saturating glitch counter for debug.

## Interface
Parameters:
- STABLE_CYCLES, default 4: number of consecutive synchronized samples at the new level needed to accept a change. Legal range 2..255.
- CNT_W, default 8: counter width. Must satisfy 2^CNT_W > STABLE_CYCLES.

Ports:
- clk  input  1  single clock. All state updates on the rising edge.
- rst  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
- din  input  1  raw asynchronous input.
- d_out  output  1  debounced level, registered. Feeds the flip-flop `d`.
- rise  output  1  one-cycle pulse, registered, coincident with d_out 0->1.
- fall  output  1  one-cycle pulse, registered, coincident with d_out 1->0.
- busy  output  1  high while a candidate change is being qualified (CHK_HIGH or CHK_LOW).
- glitch_cnt  output  8  number of aborted qualifications. Saturates at 255.

## Operation
- Synchronizer: sync1 <= din; sync2 <= sync1. Only sync2 is used downstream.
- States: IDLE_LOW, CHK_HIGH, IDLE_HIGH, CHK_LOW. cnt is CNT_W bits wide.
- IDLE_LOW:
  - sync2=1: go to CHK_HIGH, cnt<=1.
  - Otherwise hold.
- CHK_HIGH:
  - sync2=0: go to IDLE_LOW, cnt<=0, glitch_cnt++ (saturating).
  - sync2=1 and cnt==STABLE_CYCLES-1: go to IDLE_HIGH, d_out<=1, rise<=1, cnt<=0.
  - Otherwise cnt<=cnt+1.
- IDLE_HIGH and CHK_LOW: mirror images of the above, with levels inverted. Acceptance sets d_out<=0 and fall<=1.
- rise and fall default to 0 every cycle. They are never high together.
- busy is a combinational decode of state (CHK_HIGH or CHK_LOW).
- glitch_cnt holds at 255 once reached. It is cleared only by rst.
- Reset (rst=1 at an edge), effective the same edge, overriding everything else:
  - sync1, sync2, d_out, rise, fall, cnt and glitch_cnt go to 0.
  - State goes to IDLE_LOW.
  - An operation in progress is abandoned with no pulse and no glitch count.
  - If din is high across reset release, the block requalifies from scratch: the first edge with rst=0 captures sync1, then the normal latency applies.

## Timing
- Reset values: d_out=0, rise=0, fall=0, busy=0, glitch_cnt=0.
- Define E0 as the edge at which sync1 first captures the new level. sync2 holds it after E1.
- Latency from E0: d_out and the strobe change at edge E(STABLE_CYCLES+1), provided din stays stable. With the default of 4, that is E5.
- busy rises after E2 and falls after E(STABLE_CYCLES+1).
- A sync2 sample at the old level at any edge while in a CHK state aborts the qualification:
  - busy falls after that edge.
  - glitch_cnt increments after that edge.
  - d_out is unchanged.
- Pulses narrower than 1 clk may be missed entirely. This is acceptable, and they are not counted as glitches.
- No combinational path exists from din to any output.

## Test plan
With STABLE_CYCLES=4, period 20:
- Reset: hold rst=1 for 2 edges with din toggling. Required: all outputs 0, glitch_cnt=0.
- Clean rise: din 0->1 held. Required:
  - busy high after E2.
  - d_out=1 and rise=1 for exactly one cycle after E5.
  - busy=0 after E5.
- Bounce: din high for 2 cycles, low for 1, then high held. Required:
  - glitch_cnt=1.
  - d_out rises only at the fifth edge after the final sync1 capture of 1.
  - Exactly one rise pulse.
- Clean fall from d_out=1: din 1->0 held. Required: d_out=0 and fall=1 for one cycle after E5; rise never asserted.
- Reset mid-qualification: assert rst at E3 of a rise, then release with din still high. Required:
  - No rise pulse during the aborted qualification.
  - glitch_cnt stays 0.
  - d_out rises 5 edges after the first post-reset sync1 capture.
- Saturation: 300 single-sample bounces (each din high for 1 clk, then low for 3). Required: glitch_cnt ends at 255; d_out stays 0 throughout.
